arm_debug_ctrl: RTL and testbench

ARM_DEBUG_CTRL -- requirements
Module: arm_debug_ctrl

---
 rtl/arm_debug_pkg.sv | 27 ++
 rtl/key_debouncer.sv | 50 +++++
 rtl/arm_debug_ctrl.sv | 175 +++++++++++++++++
 tb/tb_arm_debug_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arm_debug_pkg.sv
// Shared definitions for the debug controller: FSM encoding, probe width
// and the active-low 7-segment font used for the hex display.
package arm_debug_pkg;

    localparam int PROBE_W = 32;
    localparam int NIBBLES = PROBE_W / 4;

    localparam logic [1:0] ST_RUN        = 2'd0;
    localparam logic [1:0] ST_STEP_IDLE  = 2'd1;
    localparam logic [1:0] ST_STEP_PULSE = 2'd2;
    localparam logic [1:0] ST_CORE_RST   = 2'd3;

    // Active-low segments, bit 0 = a ... bit 6 = g; entry 15 first.
    localparam logic [15:0][6:0] SEG_LUT = {
        7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
        7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
        7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
        7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
    };

    localparam logic [7*NIBBLES-1:0] HEX_ZERO = {NIBBLES{SEG_LUT[0]}};

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        return SEG_LUT[nib];
    endfunction

endpackage

// File: rtl/key_debouncer.sv
// Debounces one synchronized active-low key and emits a single-cycle press
// pulse when the accepted level falls from released to pressed.
module key_debouncer #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n_sync,
    output logic press
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;

    // The counter tracks how many consecutive samples disagree with the
    // accepted level; any agreeing sample restarts it.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        press_d = 1'b0;
        if (key_n_sync == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            level_d = key_n_sync;
            press_d = ~key_n_sync;
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            level_q <= 1'b1;
            press_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/arm_debug_ctrl.sv
// Board-level debug controller: run/single-step/core-reset sequencing for a
// soft processor plus a freezable hex display of a selected probe channel.
module arm_debug_ctrl
    import arm_debug_pkg::*;
#(
    parameter int NUM_PROBES      = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int RST_STRETCH     = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [2:0]                    key_n,
    input  logic                          sw_run,
    input  logic [3:0]                    sw_sel,
    input  logic [PROBE_W*NUM_PROBES-1:0] probes,
    output logic                          cpu_en,
    output logic                          cpu_rst,
    output logic [55:0]                   hex_n,
    output logic [15:0]                   step_count,
    output logic                          frozen
);
    localparam int SCNT_W = (RST_STRETCH > 1) ? $clog2(RST_STRETCH) : 1;
    localparam logic [SCNT_W-1:0] STRETCH_LOAD = SCNT_W'(RST_STRETCH - 1);
    localparam logic [SCNT_W-1:0] STRETCH_ONE  = SCNT_W'(1);

    logic [2:0]  key_s1_q, key_s1_d, key_s2_q, key_s2_d;
    logic        run_s1_q, run_s1_d, run_s2_q, run_s2_d;
    logic [3:0]  sel_s1_q, sel_s1_d, sel_s2_q, sel_s2_d;

    logic [2:0]  key_press;
    logic        step_press, core_rst_press, freeze_press;

    logic [1:0]        state_q, state_d;
    logic [SCNT_W-1:0] stretch_q, stretch_d;
    logic              boot_q, boot_d;
    logic [15:0]       step_cnt_q, step_cnt_d;
    logic              cpu_en_q, cpu_en_d;
    logic              cpu_rst_q, cpu_rst_d;

    logic              frozen_q, frozen_d;
    logic [PROBE_W-1:0] sel_word;
    logic [PROBE_W-1:0] disp_q, disp_d;
    logic [55:0]        hex_q, hex_d;

    // Two-flop synchronizers for every raw board input.
    always_comb begin
        key_s1_d = key_n;
        key_s2_d = key_s1_q;
        run_s1_d = sw_run;
        run_s2_d = run_s1_q;
        sel_s1_d = sw_sel;
        sel_s2_d = sel_s1_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_s1_q <= 3'b111;
            key_s2_q <= 3'b111;
            run_s1_q <= 1'b0;
            run_s2_q <= 1'b0;
            sel_s1_q <= 4'd0;
            sel_s2_q <= 4'd0;
        end else begin
            key_s1_q <= key_s1_d;
            key_s2_q <= key_s2_d;
            run_s1_q <= run_s1_d;
            run_s2_q <= run_s2_d;
            sel_s1_q <= sel_s1_d;
            sel_s2_q <= sel_s2_d;
        end
    end

    for (genvar k = 0; k < 3; k++) begin : g_key
        key_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk        (clk),
            .rst        (rst),
            .key_n_sync (key_s2_q[k]),
            .press      (key_press[k])
        );
    end

    assign step_press     = key_press[0];
    assign core_rst_press = key_press[1];
    assign freeze_press   = key_press[2];

    // boot_q forces one core-reset stretch right after the board reset lifts.
    // A core-reset press outranks everything except an ongoing stretch, so a
    // simultaneous step press is simply dropped.
    always_comb begin
        state_d    = state_q;
        stretch_d  = stretch_q;
        boot_d     = 1'b0;
        step_cnt_d = step_cnt_q;
        if (boot_q || (core_rst_press && state_q != ST_CORE_RST)) begin
            state_d   = ST_CORE_RST;
            stretch_d = STRETCH_LOAD;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (!run_s2_q) state_d = ST_STEP_IDLE;
                end
                ST_STEP_IDLE: begin
                    if (step_press)    state_d = ST_STEP_PULSE;
                    else if (run_s2_q) state_d = ST_RUN;
                end
                ST_STEP_PULSE: begin
                    state_d = ST_STEP_IDLE;
                end
                default: begin
                    if (stretch_q == '0) state_d = run_s2_q ? ST_RUN : ST_STEP_IDLE;
                    else                 stretch_d = stretch_q - STRETCH_ONE;
                end
            endcase
        end

        if (state_d == ST_CORE_RST)        step_cnt_d = 16'd0;
        else if (state_d == ST_STEP_PULSE) step_cnt_d = step_cnt_q + 16'd1;

        cpu_en_d  = (state_d == ST_RUN) || (state_d == ST_STEP_PULSE);
        cpu_rst_d = (state_d == ST_CORE_RST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_STEP_IDLE;
            stretch_q  <= '0;
            boot_q     <= 1'b1;
            step_cnt_q <= 16'd0;
            cpu_en_q   <= 1'b0;
            cpu_rst_q  <= 1'b1;
        end else begin
            state_q    <= state_d;
            stretch_q  <= stretch_d;
            boot_q     <= boot_d;
            step_cnt_q <= step_cnt_d;
            cpu_en_q   <= cpu_en_d;
            cpu_rst_q  <= cpu_rst_d;
        end
    end

    // Display path: probe mux -> display register -> registered 7-seg font.
    always_comb begin
        sel_word = '0;
        for (int k = 0; k < NUM_PROBES; k++) begin
            if (sel_s2_q == 4'(k)) sel_word = probes[k*PROBE_W +: PROBE_W];
        end
        frozen_d = frozen_q ^ freeze_press;
        disp_d   = frozen_q ? disp_q : sel_word;
        hex_d    = '0;
        for (int d = 0; d < NIBBLES; d++) begin
            hex_d[7*d +: 7] = hex_to_seg(disp_q[4*d +: 4]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frozen_q <= 1'b0;
            disp_q   <= '0;
            hex_q    <= HEX_ZERO;
        end else begin
            frozen_q <= frozen_d;
            disp_q   <= disp_d;
            hex_q    <= hex_d;
        end
    end

    assign cpu_en     = cpu_en_q;
    assign cpu_rst    = cpu_rst_q;
    assign step_count = step_cnt_q;
    assign frozen     = frozen_q;
    assign hex_n      = hex_q;

endmodule

// File: tb/tb_arm_debug_ctrl.sv
// Scoreboard bench for arm_debug_ctrl with a short debounce window.
module tb_arm_debug_ctrl;
    localparam int NP  = 4;
    localparam int DEB = 8;
    localparam int STR = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [2:0]        key_n;
    logic              sw_run;
    logic [3:0]        sw_sel;
    logic [32*NP-1:0]  probes;
    logic              cpu_en, cpu_rst, frozen;
    logic [55:0]       hex_n;
    logic [15:0]       step_count;

    always #5 clk = ~clk;

    arm_debug_ctrl #(
        .NUM_PROBES      (NP),
        .DEBOUNCE_CYCLES (DEB),
        .RST_STRETCH     (STR)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .key_n      (key_n),
        .sw_run     (sw_run),
        .sw_sel     (sw_sel),
        .probes     (probes),
        .cpu_en     (cpu_en),
        .cpu_rst    (cpu_rst),
        .hex_n      (hex_n),
        .step_count (step_count),
        .frozen     (frozen)
    );

    typedef struct packed {
        logic        is_rst;
        int          width;
        logic [15:0] count;
    } ev_t;

    ev_t         exp_q[$];
    int          total = 0;
    int          bad   = 0;
    logic [15:0] m_count;
    logic        m_frozen;
    logic [31:0] m_held;
    logic [31:0] m_probe[NP];
    logic [3:0]  m_sel;
    bit          mon_en = 1'b1;
    int          rst_run = 0;
    int          en_run  = 0;

    function automatic logic [6:0] seg(input logic [3:0] v);
        logic [6:0] lit;
        case (v)
            4'h0: lit = 7'h3F; 4'h1: lit = 7'h06; 4'h2: lit = 7'h5B; 4'h3: lit = 7'h4F;
            4'h4: lit = 7'h66; 4'h5: lit = 7'h6D; 4'h6: lit = 7'h7D; 4'h7: lit = 7'h07;
            4'h8: lit = 7'h7F; 4'h9: lit = 7'h6F; 4'hA: lit = 7'h77; 4'hB: lit = 7'h7C;
            4'hC: lit = 7'h39; 4'hD: lit = 7'h5E; 4'hE: lit = 7'h79; default: lit = 7'h71;
        endcase
        return ~lit;
    endfunction

    function automatic logic [55:0] hex_of(input logic [31:0] v);
        logic [55:0] r;
        for (int i = 0; i < 8; i++) r[7*i +: 7] = seg(v[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [31:0] shown();
        if (m_frozen) return m_held;
        return (m_sel < NP) ? m_probe[m_sel] : 32'h0;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    task automatic report(input logic is_rst, input int width);
        ev_t e;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_%s: got pulse of %0d cycles, required none",
                     is_rst ? "cpu_rst" : "cpu_en", width);
        end else begin
            e = exp_q.pop_front();
            chk("event_kind", is_rst, e.is_rst);
            chk("event_width", width, e.width);
            chk("event_step_count", step_count, e.count);
        end
    endtask

    // Monitor: turns cpu_rst / cpu_en activity into pulse events.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            rst_run = 0;
            en_run  = 0;
        end else begin
            if (cpu_rst) rst_run++;
            else if (rst_run > 0) begin
                report(1'b1, rst_run);
                rst_run = 0;
            end
            if (!mon_en) en_run = 0;
            else if (cpu_en) en_run++;
            else if (en_run > 0) begin
                report(1'b0, en_run);
                en_run = 0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic set_probe(input int k, input logic [31:0] v);
        m_probe[k] = v;
        probes[32*k +: 32] = v;
    endtask

    task automatic press(input logic [2:0] mask, input int hold);
        key_n = key_n & ~mask;
        tick(hold);
        key_n = 3'b111;
        tick(DEB + 6);
    endtask

    task automatic push_ev(input logic is_rst, input int width, input logic [15:0] cnt);
        ev_t e;
        e.is_rst = is_rst;
        e.width  = width;
        e.count  = cnt;
        exp_q.push_back(e);
    endtask

    task automatic do_step();
        m_count = m_count + 16'd1;
        push_ev(1'b0, 1, m_count);
        press(3'b001, $urandom_range(DEB + 2, DEB + 7));
    endtask

    task automatic do_glitch(input logic [2:0] mask);
        press(mask, $urandom_range(1, DEB - 2));
    endtask

    task automatic do_core_rst(input logic [2:0] mask);
        m_count = 16'd0;
        push_ev(1'b1, STR, 16'd0);
        press(mask, $urandom_range(DEB + 2, DEB + 7));
        tick(STR + 8);
    endtask

    task automatic do_freeze();
        if (!m_frozen) m_held = shown();
        m_frozen = ~m_frozen;
        press(3'b100, $urandom_range(DEB + 2, DEB + 7));
        chk("frozen_flag", frozen, m_frozen);
    endtask

    initial begin
        logic [31:0] old_v;
        int          n;
        rst = 1'b1; key_n = 3'b111; sw_run = 1'b0; sw_sel = 4'd0; probes = '0;
        m_count = 16'd0; m_frozen = 1'b0; m_held = 32'h0; m_sel = 4'd0;
        for (int k = 0; k < NP; k++) m_probe[k] = 32'h0;
        tick(3);
        chk("reset_cpu_rst", cpu_rst, 1'b1);
        chk("reset_cpu_en", cpu_en, 1'b0);
        chk("reset_step_count", step_count, 16'd0);
        chk("reset_frozen", frozen, 1'b0);
        chk("reset_hex", hex_n, {8{7'b1000000}});

        // Power-on core-reset stretch, then single-step idle.
        push_ev(1'b1, STR, 16'd0);
        rst = 1'b0;
        tick(STR + 6);
        chk("boot_cpu_en", cpu_en, 1'b0);
        chk("boot_cpu_rst", cpu_rst, 1'b0);
        chk("boot_hex", hex_n, hex_of(32'h0));

        for (int i = 0; i < 3; i++) do_step();
        chk("three_steps", step_count, 16'd3);

        do_glitch(3'b001);
        chk("glitch_no_step", step_count, 16'd3);

        do_core_rst(3'b011);
        chk("simul_press_count", step_count, 16'd0);

        // Step pressed a few cycles after core reset lands inside the stretch.
        m_count = 16'd0;
        push_ev(1'b1, STR, 16'd0);
        key_n[1] = 1'b0;
        tick(4);
        key_n[0] = 1'b0;
        tick(DEB + 2);
        key_n = 3'b111;
        tick(DEB + STR + 14);
        chk("step_in_stretch", step_count, 16'd0);

        do_step();
        do_step();

        // Free-run mode ignores step presses.
        mon_en = 1'b0;
        sw_run = 1'b1;
        tick(6);
        chk("run_cpu_en", cpu_en, 1'b1);
        press(3'b001, DEB + 3);
        chk("run_step_ignored", step_count, m_count);
        chk("run_cpu_en_held", cpu_en, 1'b1);
        sw_run = 1'b0;
        tick(6);
        chk("back_to_step_idle", cpu_en, 1'b0);
        mon_en = 1'b1;

        // Display: channel select, two-cycle latency, freeze, out-of-range select.
        set_probe(2, 32'hDEADBEEF);
        sw_sel = 4'd2; m_sel = 4'd2;
        tick(6);
        chk("hex_deadbeef", hex_n, hex_of(32'hDEADBEEF));
        chk("hex_digit7_d", hex_n[55:49], seg(4'hD));
        old_v = 32'hDEADBEEF;
        set_probe(2, 32'h01234567);
        tick(1);
        chk("latency_1cyc_old", hex_n, hex_of(old_v));
        tick(1);
        chk("latency_2cyc_new", hex_n, hex_of(32'h01234567));
        set_probe(2, 32'hDEADBEEF);
        tick(4);
        do_freeze();
        set_probe(2, 32'h0);
        tick(6);
        chk("frozen_hold", hex_n, hex_of(32'hDEADBEEF));
        do_freeze();
        sw_sel = 4'd9; m_sel = 4'd9;
        tick(6);
        chk("sel_out_of_range", hex_n, hex_of(32'h0));

        // Step counter wrap from 0xFFFF.
        force dut.step_cnt_q = 16'hFFFF;
        tick(2);
        release dut.step_cnt_q;
        m_count = 16'hFFFF;
        tick(1);
        chk("count_preset", step_count, 16'hFFFF);
        do_step();
        chk("count_wrap", step_count, 16'h0000);

        // Randomized mix of steps, glitches, core resets, display changes, freezes.
        for (int i = 0; i < 30; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4: do_step();
                5, 6: do_glitch(3'b001 << $urandom_range(0, 2));
                7: do_core_rst(3'b010);
                8: begin
                    for (int k = 0; k < NP; k++) set_probe(k, $urandom);
                    m_sel = 4'($urandom_range(0, 15));
                    sw_sel = m_sel;
                    tick(6);
                    chk("rand_display", hex_n, hex_of(shown()));
                end
                default: begin
                    do_freeze();
                    tick(2);
                    chk("rand_freeze_display", hex_n, hex_of(shown()));
                end
            endcase
        end
        chk("rand_step_count", step_count, m_count);

        // Board reset in the middle of a core-reset stretch.
        push_ev(1'b1, STR, 16'd0);
        key_n[1] = 1'b0;
        n = 0;
        while (!cpu_rst && n < 60) begin
            tick(1);
            n++;
        end
        chk("wait_cpu_rst", cpu_rst, 1'b1);
        tick(3);
        rst = 1'b1;
        exp_q.delete();
        tick(1);
        key_n = 3'b111;
        chk("abort_cpu_en", cpu_en, 1'b0);
        chk("abort_cpu_rst", cpu_rst, 1'b1);
        chk("abort_step_count", step_count, 16'd0);
        chk("abort_frozen", frozen, 1'b0);
        chk("abort_hex", hex_n, {8{7'b1000000}});
        m_count = 16'd0;
        m_frozen = 1'b0;
        push_ev(1'b1, STR, 16'd0);
        rst = 1'b0;
        tick(STR + 8);
        do_step();
        chk("after_abort_count", step_count, 16'd1);

        tick(40);
        chk("events_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
